// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter: pipeline writeback vs mul/div result
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_addr,
  input  logic [31:0] pipe_data,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_addr,
  input  logic [31:0] md_data,
  output logic        pipe_stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        proto_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] FORCE = 2'd2;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [3:0] wcnt;
  logic [3:0] wcnt_nxt;
  logic [3:0] wcnt_inc;
  logic       err_set;
  logic       pipe_req;
  logic       xfer;
  logic       blocked;

  // Writes to x0 are dropped so they never steal the port from mul/div.
  assign pipe_req = pipe_we && (pipe_addr != 5'd0);
  assign md_ready = !pipe_req;
  assign xfer     = md_valid && md_ready;
  assign blocked  = md_valid && !md_ready;
  assign wcnt_inc = wcnt + 4'd1;

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (blocked) begin
          wcnt_nxt  = 4'd1;
          state_nxt = (LIMIT == 4'd1) ? FORCE : WAIT;
        end
      end
      WAIT: begin
        if (xfer) begin
          state_nxt = IDLE;
          wcnt_nxt  = 4'd0;
        end else if (blocked) begin
          wcnt_nxt = wcnt_inc;
          if (wcnt_inc == LIMIT) state_nxt = FORCE;
        end else begin
          // md_valid withdrawn before it was accepted
          err_set   = 1'b1;
          state_nxt = IDLE;
          wcnt_nxt  = 4'd0;
        end
      end
      FORCE: begin
        if (xfer) begin
          state_nxt = IDLE;
          wcnt_nxt  = 4'd0;
        end else if (blocked) begin
          // pipeline ignored the stall; it still wins and the bubble is retried
          err_set = 1'b1;
        end else begin
          err_set   = 1'b1;
          state_nxt = IDLE;
          wcnt_nxt  = 4'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        wcnt_nxt  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wcnt       <= 4'd0;
      pipe_stall <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      wcnt       <= wcnt_nxt;
      pipe_stall <= (state_nxt == FORCE);
      if (err_set) proto_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= 32'd0;
    end else if (pipe_req) begin
      rf_we    <= 1'b1;
      rf_waddr <= pipe_addr;
      rf_wdata <= pipe_data;
    end else if (xfer && (md_addr != 5'd0)) begin
      rf_we    <= 1'b1;
      rf_waddr <= md_addr;
      rf_wdata <= md_data;
    end else begin
      rf_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic        pipe_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        proto_err;

  int errors = 0;
  int checks = 0;

  wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_we    (pipe_we),
    .pipe_addr  (pipe_addr),
    .pipe_data  (pipe_data),
    .md_valid   (md_valid),
    .md_ready   (md_ready),
    .md_addr    (md_addr),
    .md_data    (md_data),
    .pipe_stall (pipe_stall),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    pipe_we   = 1'b0;
    pipe_addr = 5'd0;
    pipe_data = 32'd0;
    md_valid  = 1'b0;
    md_addr   = 5'd0;
    md_data   = 32'd0;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
    checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_rf_waddr got=%0d exp=0", rf_waddr); end
    checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_rf_wdata got=%h exp=0", rf_wdata); end
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL reset_pipe_stall got=%b exp=0", pipe_stall); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err got=%b exp=0", proto_err); end
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL reset_md_ready got=%b exp=1", md_ready); end
    checks++; if (dut.wcnt !== 4'd0) begin errors++; $display("FAIL reset_wcnt got=%0d exp=0", dut.wcnt); end
  endtask

  task automatic test_pipe_only();
    pipe_we = 1'b1; pipe_addr = 5'd5; pipe_data = 32'hDEADBEEF;
    #1;
    checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL pipe_md_ready got=%b exp=0", md_ready); end
    tick();
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL pipe_rf_we got=%b exp=1", rf_we); end
    checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL pipe_rf_waddr got=%0d exp=5", rf_waddr); end
    checks++; if (rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL pipe_rf_wdata got=%h exp=deadbeef", rf_wdata); end
    pipe_addr = 5'd0; pipe_data = 32'h11111111;
    #1;
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL pipe_x0_md_ready got=%b exp=1", md_ready); end
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL pipe_x0_rf_we got=%b exp=0", rf_we); end
    checks++; if (rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL pipe_x0_hold_wdata got=%h exp=deadbeef", rf_wdata); end
    quiet();
    tick();
  endtask

  task automatic test_md_idle();
    md_valid = 1'b1; md_addr = 5'd7; md_data = 32'h12345678;
    #1;
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL md_idle_ready got=%b exp=1", md_ready); end
    tick();
    quiet();
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL md_idle_rf_we got=%b exp=1", rf_we); end
    checks++; if (rf_waddr !== 5'd7) begin errors++; $display("FAIL md_idle_rf_waddr got=%0d exp=7", rf_waddr); end
    checks++; if (rf_wdata !== 32'h12345678) begin errors++; $display("FAIL md_idle_rf_wdata got=%h exp=12345678", rf_wdata); end
    checks++; if (dut.state !== 2'd0) begin errors++; $display("FAIL md_idle_state got=%0d exp=0", dut.state); end
    tick();
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL md_idle_proto_err got=%b exp=0", proto_err); end
  endtask

  // Pipeline hogs the port from cycle N; returns with the DUT in cycle N+4.
  task automatic starve_to_force();
    pipe_we = 1'b1; pipe_addr = 5'd3; pipe_data = 32'h00000033;
    md_valid = 1'b1; md_addr = 5'd9; md_data = 32'hA5A5A5A5;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL starve_early_stall k=%0d got=%b exp=0", k, pipe_stall); end
      tick();
    end
  endtask

  task automatic test_starvation();
    do_reset();
    starve_to_force();
    checks++; if (pipe_stall !== 1'b1) begin errors++; $display("FAIL starve_stall got=%b exp=1", pipe_stall); end
    checks++; if (rf_waddr !== 5'd3) begin errors++; $display("FAIL starve_pipe_wrote got=%0d exp=3", rf_waddr); end
    pipe_we = 1'b0; pipe_addr = 5'd0;
    #1;
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL starve_md_ready got=%b exp=1", md_ready); end
    tick();
    md_valid = 1'b0;
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL starve_rf_we got=%b exp=1", rf_we); end
    checks++; if (rf_waddr !== 5'd9) begin errors++; $display("FAIL starve_rf_waddr got=%0d exp=9", rf_waddr); end
    checks++; if (rf_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL starve_rf_wdata got=%h exp=a5a5a5a5", rf_wdata); end
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL starve_stall_drop got=%b exp=0", pipe_stall); end
    tick();
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL starve_proto_err got=%b exp=0", proto_err); end
  endtask

  task automatic test_x0();
    md_valid = 1'b1; md_addr = 5'd0; md_data = 32'hCAFECAFE;
    #1;
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL x0_md_ready got=%b exp=1", md_ready); end
    tick();
    md_valid = 1'b0;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_md_rf_we got=%b exp=0", rf_we); end
    checks++; if (rf_waddr !== 5'd9) begin errors++; $display("FAIL x0_md_hold_waddr got=%0d exp=9", rf_waddr); end
    pipe_we = 1'b1; pipe_addr = 5'd0; pipe_data = 32'hFFFFFFFF;
    md_valid = 1'b1; md_addr = 5'd4; md_data = 32'h00000444;
    #1;
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL x0_pipe_md_ready got=%b exp=1", md_ready); end
    tick();
    quiet();
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL x0_pipe_rf_we got=%b exp=1", rf_we); end
    checks++; if (rf_waddr !== 5'd4) begin errors++; $display("FAIL x0_pipe_rf_waddr got=%0d exp=4", rf_waddr); end
    checks++; if (rf_wdata !== 32'h00000444) begin errors++; $display("FAIL x0_pipe_rf_wdata got=%h exp=00000444", rf_wdata); end
    tick();
  endtask

  task automatic test_proto_force();
    do_reset();
    starve_to_force();
    pipe_addr = 5'd6; pipe_data = 32'h66666666;
    #1;
    checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL pforce_md_ready got=%b exp=0", md_ready); end
    tick();
    checks++; if (rf_waddr !== 5'd6) begin errors++; $display("FAIL pforce_pipe_wrote got=%0d exp=6", rf_waddr); end
    checks++; if (pipe_stall !== 1'b1) begin errors++; $display("FAIL pforce_stall_hold got=%b exp=1", pipe_stall); end
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL pforce_proto_err got=%b exp=1", proto_err); end
    pipe_we = 1'b0; pipe_addr = 5'd0;
    tick();
    md_valid = 1'b0;
    checks++; if (rf_waddr !== 5'd9) begin errors++; $display("FAIL pforce_md_retire got=%0d exp=9", rf_waddr); end
    tick();
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL pforce_sticky got=%b exp=1", proto_err); end
  endtask

  task automatic test_proto_drop();
    do_reset();
    pipe_we = 1'b1; pipe_addr = 5'd2; pipe_data = 32'h2;
    md_valid = 1'b1; md_addr = 5'd8; md_data = 32'h8;
    tick();
    tick();
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL pdrop_before got=%b exp=0", proto_err); end
    quiet();
    tick();
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL pdrop_proto_err got=%b exp=1", proto_err); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL pdrop_rf_we got=%b exp=0", rf_we); end
  endtask

  task automatic test_reset_in_force();
    do_reset();
    starve_to_force();
    pipe_addr = 5'd6;
    tick();
    checks++; if (pipe_stall !== 1'b1) begin errors++; $display("FAIL rforce_pre_stall got=%b exp=1", pipe_stall); end
    rst = 1'b1;
    tick();
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL rforce_stall got=%b exp=0", pipe_stall); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rforce_rf_we got=%b exp=0", rf_we); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rforce_proto_err got=%b exp=0", proto_err); end
    checks++; if (dut.wcnt !== 4'd0) begin errors++; $display("FAIL rforce_wcnt got=%0d exp=0", dut.wcnt); end
    rst = 1'b0;
    quiet();
    tick();
  endtask

  initial begin
    quiet();
    rst = 1'b1;
    tick();
    test_reset();
    test_pipe_only();
    test_md_idle();
    test_starvation();
    test_x0();
    test_proto_force();
    test_proto_drop();
    test_reset_in_force();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbitrates the single register-file write port between the in-order pipeline writeback (output of the WB stage) and the long-latency multiply/divide unit. The pipeline has fixed priority and is never back-pressured in normal operation. A starvation counter forces a one-cycle writeback bubble so the mul/div result can retire. The port drive to the register file is registered, with one cycle of latency from either source.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive blocked cycles of a pending mul/div result before a pipeline bubble is forced; legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- pipe_we  in  1  pipeline writeback request (reg_write_enable of WB stage)
- pipe_addr  in  5  pipeline destination register
- pipe_data  in  32  pipeline writeback data
- md_valid  in  1  mul/div result pending
- md_ready  out  1  combinational accept for mul/div result
- md_addr  in  5  mul/div destination register
- md_data  in  32  mul/div result
- pipe_stall  out  1  registered; forces an empty writeback slot this cycle
- rf_we  out  1  registered register-file write enable
- rf_waddr  out  5  registered write address
- rf_wdata  out  32  registered write data
- proto_err  out  1  sticky protocol-violation flag

## Operation
- Effective pipeline request: pipe_req = pipe_we && pipe_addr != 0. A write to x0 never occupies the port.
- md_ready = !pipe_req. Transfer occurs when md_valid && md_ready.
- The mul/div unit holds md_valid, md_addr and md_data stable until transfer.
- Port register update each cycle:
  - If pipe_req: rf_we=1, rf_waddr=pipe_addr, rf_wdata=pipe_data.
  - Else if transfer with md_addr != 0: load the md fields into the port register.
  - Else if transfer with md_addr == 0: the result is accepted and discarded; rf_we=0.
  - Otherwise rf_we=0. rf_waddr and rf_wdata hold their previous values.
- The FSM uses a wait counter wcnt of 4 bits.
  - IDLE: md_valid=0, wcnt=0. On md_valid && !md_ready, go to WAIT with wcnt=1. On transfer, stay in IDLE.
  - WAIT: each blocked cycle increments wcnt. On transfer, go to IDLE and clear wcnt. When a blocked cycle brings wcnt to STARVE_LIMIT, go to FORCE.
  - FORCE: pipe_stall=1. Upstream guarantees pipe_we=0 (or pipe_addr=0) in every cycle pipe_stall is high, so the transfer happens. On transfer, go to IDLE, clear wcnt and drop pipe_stall.
- Precedence in FORCE: if pipe_req arrives anyway, the pipeline still wins, md stays blocked, FORCE holds, and proto_err is set.
- proto_err is also set when md_valid falls without a transfer. It clears only on rst.
- WAW ordering between the two sources is not checked here; the issue-side scoreboard owns it.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, pipe_stall=0, proto_err=0, state=IDLE, wcnt=0. md_ready follows its combinational equation after reset.
- Latency: a request accepted in cycle N drives rf_* in cycle N+1.
- md_ready has no register stage: it depends only on the pipe_* inputs of the same cycle.
- pipe_stall is registered from the FSM state, with no combinational path from inputs.
- Starvation, STARVE_LIMIT=L: md blocked in cycles N..N+L-1, pipe_stall=1 at N+L, transfer at N+L, rf_we from md at N+L+1, pipe_stall=0 at N+L+1.
- Simultaneous pipe_req and md_valid: pipe writes, md waits, and the wait counts as blocked.
- Synchronous rst mid-operation (any state, including FORCE) returns everything to reset values on the next edge. No write is issued in the cycle after rst.

## Test plan
- Pipeline-only traffic: pipe_we=1, addr=5, data=0xDEADBEEF at cycle N -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF at N+1. pipe_addr=0 -> rf_we=0.
- Idle-port mul/div: md_valid=1, addr=7, data=0x12345678, pipe_we=0 -> md_ready=1 the same cycle, rf_we with addr 7 and data 0x12345678 next cycle, FSM stays in IDLE.
- Starvation with L=4: pipe_req held every cycle, md_valid from N -> pipe_stall=1 exactly at N+4. The bench then drops pipe_we, the md transfer occurs at N+4, rf_we from md at N+5, pipe_stall=0 at N+5.
- x0 handling: md_addr=0 with the port free -> md_ready=1, transfer consumed, rf_we=0 next cycle. pipe_addr=0 with pipe_we=1 while md pending -> md granted.
- Protocol errors:
  - pipe_req while pipe_stall=1 -> pipeline written, md_ready=0, proto_err=1 thereafter.
  - Separate run: md_valid dropped while blocked -> proto_err=1.
- Reset in FORCE: assert rst while pipe_stall=1 -> next cycle pipe_stall=0, rf_we=0, proto_err=0, wcnt=0.
